// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I decode stage: op classes, opcodes,
// immediate formats and the decode-to-execute bundle.
package rv32i_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_LUI    = 4'd1,
      OP_AUIPC  = 4'd2,
      OP_JAL    = 4'd3,
      OP_JALR   = 4'd4,
      OP_BRANCH = 4'd5,
      OP_LOAD   = 4'd6,
      OP_STORE  = 4'd7,
      OP_OPIMM  = 4'd8,
      OP_OP     = 4'd9,
      OP_SYSTEM = 4'd10
   } op_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   typedef struct packed {
      logic [31:0] pc;
      op_e         op;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [4:0]  rd;
      logic        rd_we;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        use_imm;
   } decoded_t;

   function automatic logic uses_rs1(input op_e op);
      return op inside {OP_JALR, OP_BRANCH, OP_LOAD,
                        OP_STORE, OP_OPIMM, OP_OP};
   endfunction

   function automatic logic uses_rs2(input op_e op);
      return op inside {OP_BRANCH, OP_STORE, OP_OP};
   endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for the
// selected RV32I instruction format.
import rv32i_pkg::*;

module rv32i_imm_gen (
   input  logic [31:7] instr_i,
   input  imm_fmt_e    fmt_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = '0;
      unique case (fmt_i)
         IMM_I: imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
         IMM_S: imm_o = {{21{instr_i[31]}}, instr_i[30:25],
                         instr_i[11:7]};
         IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U: imm_o = {instr_i[31:12], 12'b0};
         IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_decode.sv
// RV32I decode stage with load-use interlock and flush.
// RV32I_DECODE_ILLEGAL_TRAP_EN adds ex_illegal_o for illegal encodings.
import rv32i_pkg::*;

module rv32i_decode #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            fetch_valid_i,
   input  logic [31:0]     fetch_instr_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   output logic            fetch_ready_o,
   input  logic            flush_i,
   input  logic            ex_load_valid_i,
   input  logic [4:0]      ex_load_rd_i,
   output logic [4:0]      rf_rs1_addr_o,
   output logic [4:0]      rf_rs2_addr_o,
   input  logic [XLEN-1:0] rf_rs1_data_i,
   input  logic [XLEN-1:0] rf_rs2_data_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [3:0]      ex_op_o,
   output logic [2:0]      ex_funct3_o,
   output logic            ex_funct7b5_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_rd_we_o,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic            ex_use_imm_o
`ifdef RV32I_DECODE_ILLEGAL_TRAP_EN
   ,
   output logic            ex_illegal_o
`endif
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   op_e         op;
   imm_fmt_e    fmt;
   logic        legal;
   logic        wr;
   logic        ui;
   logic [31:0] imm;
   logic        hazard;
   logic        accept;
   logic        valid_d, valid_q;
   decoded_t    ex_d, ex_q;

   assign opc = fetch_instr_i[6:0];
   assign f3  = fetch_instr_i[14:12];
   assign f7  = fetch_instr_i[31:25];

   assign rf_rs1_addr_o = fetch_instr_i[19:15];
   assign rf_rs2_addr_o = fetch_instr_i[24:20];

   always_comb begin
      op    = OP_NOP;
      fmt   = IMM_NONE;
      legal = 1'b0;
      wr    = 1'b0;
      ui    = 1'b0;
      unique case (opc)
         OPC_LUI: begin
            op = OP_LUI; fmt = IMM_U;
            legal = 1'b1; wr = 1'b1; ui = 1'b1;
         end
         OPC_AUIPC: begin
            op = OP_AUIPC; fmt = IMM_U;
            legal = 1'b1; wr = 1'b1; ui = 1'b1;
         end
         OPC_JAL: begin
            op = OP_JAL; fmt = IMM_J;
            legal = 1'b1; wr = 1'b1;
         end
         OPC_JALR: begin
            op = OP_JALR; fmt = IMM_I;
            legal = (f3 == 3'd0); wr = 1'b1; ui = 1'b1;
         end
         OPC_BRANCH: begin
            op = OP_BRANCH; fmt = IMM_B;
            legal = (f3 != 3'd2) && (f3 != 3'd3);
         end
         OPC_LOAD: begin
            op = OP_LOAD; fmt = IMM_I;
            legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            wr = 1'b1; ui = 1'b1;
         end
         OPC_STORE: begin
            op = OP_STORE; fmt = IMM_S;
            legal = f3 inside {3'd0, 3'd1, 3'd2};
            ui = 1'b1;
         end
         OPC_OPIMM: begin
            op = OP_OPIMM; fmt = IMM_I;
            wr = 1'b1; ui = 1'b1;
            // Only the shift-immediates constrain funct7
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
         end
         OPC_OP: begin
            op = OP_OP; wr = 1'b1;
            legal = (f7 == 7'h00) ||
                    ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
         end
         OPC_FENCE: begin
            op = OP_NOP; legal = (f3 == 3'd0);
         end
         OPC_SYSTEM: begin
            op = OP_SYSTEM;
            legal = (fetch_instr_i[31:7] == 25'h0000000) ||
                    (fetch_instr_i[31:7] == 25'h0002000);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         op  = OP_NOP;
         fmt = IMM_NONE;
         wr  = 1'b0;
         ui  = 1'b0;
      end
   end

   rv32i_imm_gen u_imm_gen (
      .instr_i (fetch_instr_i[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   always_comb begin
      ex_d          = '0;
      ex_d.pc       = fetch_pc_i;
      ex_d.op       = op;
      ex_d.funct3   = f3;
      ex_d.funct7b5 = fetch_instr_i[30];
      ex_d.rd       = wr ? fetch_instr_i[11:7] : 5'd0;
      ex_d.rd_we    = wr && (fetch_instr_i[11:7] != 5'd0);
      ex_d.rs1_data = rf_rs1_data_i;
      ex_d.rs2_data = rf_rs2_data_i;
      ex_d.imm      = imm;
      ex_d.use_imm  = ui;
   end

   assign hazard = ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
                   ((uses_rs1(op) && (ex_load_rd_i == rf_rs1_addr_o)) ||
                    (uses_rs2(op) && (ex_load_rd_i == rf_rs2_addr_o)));

   assign fetch_ready_o = (!valid_q || ex_ready_i) && !hazard;
   assign accept = fetch_valid_i && fetch_ready_o && !flush_i;

   always_comb begin
      valid_d = valid_q;
      if (flush_i)         valid_d = 1'b0;
      else if (accept)     valid_d = 1'b1;
      else if (ex_ready_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         ex_q    <= '0;
         ex_q.pc <= RESET_PC;
         ex_q.op <= OP_NOP;
      end else begin
         valid_q <= valid_d;
         if (accept) ex_q <= ex_d;
      end
   end

`ifdef RV32I_DECODE_ILLEGAL_TRAP_EN
   logic ill_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)     ill_q <= 1'b0;
      else if (accept) ill_q <= !legal;
   end

   assign ex_illegal_o = ill_q;
`endif

   assign ex_valid_o    = valid_q;
   assign ex_pc_o       = ex_q.pc;
   assign ex_op_o       = ex_q.op;
   assign ex_funct3_o   = ex_q.funct3;
   assign ex_funct7b5_o = ex_q.funct7b5;
   assign ex_rd_o       = ex_q.rd;
   assign ex_rd_we_o    = ex_q.rd_we;
   assign ex_rs1_data_o = ex_q.rs1_data;
   assign ex_rs2_data_o = ex_q.rs2_data;
   assign ex_imm_o      = ex_q.imm;
   assign ex_use_imm_o  = ex_q.use_imm;

endmodule
